// File: rtl/clk_gen_sched.sv
// Divide-factor scheduler for clk_gen: manual up/down steps with a settle hold-off,
// plus a timed automatic sweep. Define CLK_GEN_SCHED_WRAP_EN to make the sweep wrap at the limits.
module clk_gen_sched #(
    parameter int FACTOR_W    = 5,
    parameter int FACTOR_MAX  = 31,
    parameter int FACTOR_MIN  = 0,
    parameter int FACTOR_INIT = 0,
    parameter int HOLD        = 4,
    parameter int DWELL_W     = 16
) (
    input  logic                clk_gen_sched_fsys,
    input  logic                clk_gen_sched_rst,
    input  logic                clk_gen_sched_up,
    input  logic                clk_gen_sched_down,
    input  logic                clk_gen_sched_sweep,
    input  logic                clk_gen_sched_dir,
    input  logic [DWELL_W-1:0]  clk_gen_sched_dwell,
    output logic [FACTOR_W-1:0] clk_gen_sched_factor,
    output logic                clk_gen_sched_update,
    output logic                clk_gen_sched_busy,
    output logic                clk_gen_sched_at_limit
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [FACTOR_W-1:0] MAX_F     = FACTOR_W'(FACTOR_MAX);
    localparam logic [FACTOR_W-1:0] MIN_F     = FACTOR_W'(FACTOR_MIN);
    localparam logic [FACTOR_W-1:0] INIT_F    = FACTOR_W'(FACTOR_INIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SWEEP
    } state_t;

    state_t               state_reg, state_next;
    logic [FACTOR_W-1:0]  factor_reg, factor_next;
    logic                 update_reg, update_next;
    logic [HOLD_W-1:0]    hold_cnt_reg, hold_cnt_next;
    logic [DWELL_W-1:0]   dwell_cnt_reg, dwell_cnt_next;
    logic [DWELL_W-1:0]   dwell_last_reg, dwell_last_next;

    logic [1:0] btn;
    logic [1:0] btn_edge;
    logic       edge_up;
    logic       edge_down;

    assign btn       = {clk_gen_sched_down, clk_gen_sched_up};
    assign edge_up   = btn_edge[0];
    assign edge_down = btn_edge[1];

    // Previous-level registers run every cycle so a level held through busy never fires later.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            logic btn_q_reg;
            always_ff @(posedge clk_gen_sched_fsys) begin
                if (clk_gen_sched_rst) begin
                    btn_q_reg <= 1'b0;
                end else begin
                    btn_q_reg <= btn[gi];
                end
            end
            assign btn_edge[gi] = btn[gi] & ~btn_q_reg;
        end
    endgenerate

    // Terminal count of the dwell counter; a dwell of 0 behaves like 1.
    logic [DWELL_W-1:0] dwell_term;
    assign dwell_term = (clk_gen_sched_dwell == '0) ? '0 : clk_gen_sched_dwell - 1'b1;

    logic [FACTOR_W-1:0] sweep_target;
    logic                sweep_move;

    always_comb begin
        sweep_target = factor_reg;
        sweep_move   = 1'b0;
        if (clk_gen_sched_dir) begin
            if (factor_reg < MAX_F) begin
                sweep_target = factor_reg + 1'b1;
                sweep_move   = 1'b1;
            end else begin
`ifdef CLK_GEN_SCHED_WRAP_EN
                sweep_target = MIN_F;
                sweep_move   = 1'b1;
`else
                sweep_target = factor_reg;
                sweep_move   = 1'b0;
`endif
            end
        end else begin
            if (factor_reg > MIN_F) begin
                sweep_target = factor_reg - 1'b1;
                sweep_move   = 1'b1;
            end else begin
`ifdef CLK_GEN_SCHED_WRAP_EN
                sweep_target = MAX_F;
                sweep_move   = 1'b1;
`else
                sweep_target = factor_reg;
                sweep_move   = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        factor_next     = factor_reg;
        update_next     = 1'b0;
        hold_cnt_next   = hold_cnt_reg;
        dwell_cnt_next  = dwell_cnt_reg;
        dwell_last_next = dwell_last_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clk_gen_sched_sweep) begin
                    state_next      = ST_SWEEP;
                    dwell_cnt_next  = '0;
                    dwell_last_next = dwell_term;
                end else if (edge_up && !edge_down && factor_reg < MAX_F) begin
                    factor_next   = factor_reg + 1'b1;
                    update_next   = 1'b1;
                    state_next    = ST_HOLD;
                    hold_cnt_next = '0;
                end else if (edge_down && !edge_up && factor_reg > MIN_F) begin
                    factor_next   = factor_reg - 1'b1;
                    update_next   = 1'b1;
                    state_next    = ST_HOLD;
                    hold_cnt_next = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    if (clk_gen_sched_sweep) begin
                        state_next      = ST_SWEEP;
                        dwell_cnt_next  = '0;
                        dwell_last_next = dwell_term;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            ST_SWEEP: begin
                if (!clk_gen_sched_sweep) begin
                    state_next = ST_IDLE;
                end else if (dwell_cnt_reg == dwell_last_reg) begin
                    // Dwell and direction take effect only here, at the step cycle.
                    dwell_cnt_next  = '0;
                    dwell_last_next = dwell_term;
                    factor_next     = sweep_target;
                    update_next     = sweep_move;
                end else begin
                    dwell_cnt_next = dwell_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_gen_sched_fsys) begin
        if (clk_gen_sched_rst) begin
            state_reg      <= ST_IDLE;
            factor_reg     <= INIT_F;
            update_reg     <= 1'b0;
            hold_cnt_reg   <= '0;
            dwell_cnt_reg  <= '0;
            dwell_last_reg <= '0;
        end else begin
            state_reg      <= state_next;
            factor_reg     <= factor_next;
            update_reg     <= update_next;
            hold_cnt_reg   <= hold_cnt_next;
            dwell_cnt_reg  <= dwell_cnt_next;
            dwell_last_reg <= dwell_last_next;
        end
    end

    assign clk_gen_sched_factor   = factor_reg;
    assign clk_gen_sched_update   = update_reg;
    assign clk_gen_sched_busy     = (state_reg != ST_IDLE);
    assign clk_gen_sched_at_limit = (factor_reg == MAX_F) || (factor_reg == MIN_F);

endmodule

// File: tb/tb_clk_gen_sched.sv
// Bench for clk_gen_sched: directed literal checks, then random stimulus compared every cycle
// against a deadline-based behavioural model. Honours CLK_GEN_SCHED_WRAP_EN like the design.
module tb_clk_gen_sched;

    localparam int FW    = 5;
    localparam int FMAX  = 31;
    localparam int FMIN  = 0;
    localparam int FINIT = 0;
    localparam int HOLD  = 4;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst, up, down, sweep, dir;
    logic [DW-1:0] dwell;
    logic [FW-1:0] factor;
    logic          update, busy, at_limit;

    int n_checks = 0;
    int n_pass   = 0;

    clk_gen_sched #(
        .FACTOR_W(FW), .FACTOR_MAX(FMAX), .FACTOR_MIN(FMIN),
        .FACTOR_INIT(FINIT), .HOLD(HOLD), .DWELL_W(DW)
    ) dut (
        .clk_gen_sched_fsys    (clk),
        .clk_gen_sched_rst     (rst),
        .clk_gen_sched_up      (up),
        .clk_gen_sched_down    (down),
        .clk_gen_sched_sweep   (sweep),
        .clk_gen_sched_dir     (dir),
        .clk_gen_sched_dwell   (dwell),
        .clk_gen_sched_factor  (factor),
        .clk_gen_sched_update  (update),
        .clk_gen_sched_busy    (busy),
        .clk_gen_sched_at_limit(at_limit)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Model: mode 0 idle, 1 hold-off, 2 sweep; deadlines are absolute clock-edge numbers.
    int m_factor = FINIT;
    int m_mode = 0;
    int m_k = 0;
    int m_hold_end = 0;
    int m_step_at = 0;
    bit m_upd = 1'b0;
    bit m_pu = 1'b0;
    bit m_pd = 1'b0;
    bit m_valid = 1'b0;

    task automatic sweep_step(input bit dr);
        if (dr) begin
            if (m_factor < FMAX) begin m_factor++; m_upd = 1'b1; end
`ifdef CLK_GEN_SCHED_WRAP_EN
            else begin m_factor = FMIN; m_upd = 1'b1; end
`endif
        end else begin
            if (m_factor > FMIN) begin m_factor--; m_upd = 1'b1; end
`ifdef CLK_GEN_SCHED_WRAP_EN
            else begin m_factor = FMAX; m_upd = 1'b1; end
`endif
        end
    endtask

    task automatic model_step(input bit r, input bit u, input bit dn, input bit sw,
                              input bit dr, input int dwl);
        bit eu;
        bit ed;
        int len;
        eu  = u && !m_pu;
        ed  = dn && !m_pd;
        len = (dwl == 0) ? 1 : dwl;
        m_k++;
        if (r) begin
            m_factor = FINIT;
            m_upd    = 1'b0;
            m_mode   = 0;
            m_valid  = 1'b1;
        end else begin
            m_upd = 1'b0;
            if (m_mode == 0) begin
                if (sw) begin
                    m_mode = 2; m_step_at = m_k + len;
                end else if (eu && !ed && m_factor < FMAX) begin
                    m_factor++; m_upd = 1'b1; m_mode = 1; m_hold_end = m_k + HOLD;
                end else if (ed && !eu && m_factor > FMIN) begin
                    m_factor--; m_upd = 1'b1; m_mode = 1; m_hold_end = m_k + HOLD;
                end
            end else if (m_mode == 1) begin
                if (m_k == m_hold_end) begin
                    if (sw) begin m_mode = 2; m_step_at = m_k + len; end
                    else m_mode = 0;
                end
            end else begin
                if (!sw) m_mode = 0;
                else if (m_k == m_step_at) begin
                    m_step_at = m_k + len;
                    sweep_step(dr);
                end
            end
        end
        m_pu = r ? 1'b0 : u;
        m_pd = r ? 1'b0 : dn;
    endtask

    // Model advances on every rising edge; outputs are compared on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step(rst, up, down, sweep, dir, int'(dwell));
            @(negedge clk);
            if (m_valid) begin
                chk("model_factor", int'(factor), m_factor);
                chk("model_update", int'(update), int'(m_upd));
                chk("model_busy", int'(busy), (m_mode != 0) ? 1 : 0);
                chk("model_at_limit", int'(at_limit), (m_factor == FMAX || m_factor == FMIN) ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_factor(input int target, input string name);
        int n;
        n = 0;
        while (int'(factor) != target && n < 100) begin
            tick();
            n++;
        end
        chk(name, int'(factor), target);
    endtask

    initial begin
        rst = 1'b1; up = 1'b0; down = 1'b0; sweep = 1'b0; dir = 1'b1; dwell = 16'd3;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_factor", int'(factor), 0);
        chk("rst_update", int'(update), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_limit", int'(at_limit), 1);
        repeat (2) tick();

        // Manual up step, then a dropped request inside the hold-off.
        up = 1'b1; tick(); up = 1'b0;
        chk("up_factor", int'(factor), 1);
        chk("up_update", int'(update), 1);
        chk("up_busy", int'(busy), 1);
        tick();
        chk("up_update_once", int'(update), 0);
        up = 1'b1; tick(); up = 1'b0;
        tick();
        chk("hold_busy_last", int'(busy), 1);
        tick();
        chk("hold_released", int'(busy), 0);
        chk("hold_dropped", int'(factor), 1);

        up = 1'b1; down = 1'b1; tick(); up = 1'b0; down = 1'b0;
        chk("both_factor", int'(factor), 1);
        chk("both_update", int'(update), 0);

        // Sweep with dwell 3 from factor 1.
        dir = 1'b1; dwell = 16'd3; sweep = 1'b1; tick();
        chk("sw_enter_busy", int'(busy), 1);
        chk("sw_enter_update", int'(update), 0);
        tick(); tick();
        chk("sw_wait_factor", int'(factor), 1);
        tick();
        chk("sw3_step1", int'(factor), 2);
        chk("sw3_upd1", int'(update), 1);
        tick(); tick();
        chk("sw3_gap", int'(update), 0);
        tick();
        chk("sw3_step2", int'(factor), 3);

        sweep = 1'b0; tick();
        chk("sw_exit_busy", int'(busy), 0);
        chk("sw_exit_factor", int'(factor), 3);
        dwell = 16'd0; sweep = 1'b1; tick(); tick();
        chk("sw0_step1", int'(factor), 4);
        chk("sw0_upd1", int'(update), 1);
        tick();
        chk("sw0_step2", int'(factor), 5);
        chk("sw0_upd2", int'(update), 1);

        wait_factor(31, "reach_max");
        tick();
`ifdef CLK_GEN_SCHED_WRAP_EN
        chk("wrap_factor", int'(factor), 0);
        chk("wrap_update", int'(update), 1);
        wait_factor(31, "reach_max_again");
`else
        chk("sat_factor", int'(factor), 31);
        chk("sat_update", int'(update), 0);
        chk("sat_at_limit", int'(at_limit), 1);
`endif
        sweep = 1'b0; tick();
        chk("max_idle_factor", int'(factor), 31);
        up = 1'b1; tick(); up = 1'b0;
        chk("max_up_factor", int'(factor), 31);
        chk("max_up_update", int'(update), 0);
        chk("max_up_busy", int'(busy), 0);

        // Reset in the middle of a downward sweep.
        dir = 1'b0; sweep = 1'b1;
        wait_factor(17, "reach_17");
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_factor", int'(factor), 0);
        chk("midrst_update", int'(update), 0);
        chk("midrst_busy", int'(busy), 0);
        tick();
        chk("midrst_resweep", int'(busy), 1);
        sweep = 1'b0; tick();
        chk("midrst_idle", int'(busy), 0);
        down = 1'b1; tick(); down = 1'b0;
        chk("min_down_factor", int'(factor), 0);
        chk("min_down_update", int'(update), 0);
        chk("min_at_limit", int'(at_limit), 1);

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            up   = ($urandom_range(0, 3) == 0);
            down = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            if ($urandom_range(0, 59) == 0) sweep = ~sweep;
            if (!sweep && $urandom_range(0, 9) == 0) dwell = DW'($urandom_range(0, 5));
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; up = 1'b0; down = 1'b0; sweep = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
